// File: rtl/arb2_pkg.sv
// ----------------------------------------------------------------------------
// arb2_pkg
// Shared definitions for the two-requester round-robin arbiter:
//   - state_e        : output-register state encoding (EMPTY / FULL)
//   - ARB2_DATA_W    : default datapath width
//   - ARB2_CNT_W     : default grant-counter width
//   - LAST_SRC_RST   : reset value of the round-robin pointer. It is set to 1
//                      so requester 0 wins the first contention after reset.
// ----------------------------------------------------------------------------
package arb2_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int   ARB2_DATA_W  = 32;
    localparam int   ARB2_CNT_W   = 16;
    localparam logic LAST_SRC_RST = 1'b1;

endpackage : arb2_pkg

// File: rtl/mux2to1.sv
// ----------------------------------------------------------------------------
// mux2to1
// Plain combinational 2:1 word multiplexer used as the shared datapath.
// Ports:
//   sel_i   : 0 selects a0_i, 1 selects a1_i
//   a0_i    : input word 0 (DATA_W)
//   a1_i    : input word 1 (DATA_W)
//   y_o     : selected word (DATA_W)
// ----------------------------------------------------------------------------
module mux2to1 #(
    parameter int DATA_W = 32
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] a0_i,
    input  logic [DATA_W-1:0] a1_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = sel_i ? a1_i : a0_i;

endmodule : mux2to1

// File: rtl/arb2_rr_ctrl.sv
// ----------------------------------------------------------------------------
// arb2_rr_ctrl
// Two-requester round-robin arbiter and output-register controller for a
// shared 2:1 datapath mux. The winning word is registered and presented
// downstream over valid/ready; a full register may drain and reload in the
// same cycle, so sustained throughput is one word per clock.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in0_valid/in0_data/in0_ready : requester 0 handshake
//   in1_valid/in1_data/in1_ready : requester 1 handshake
//   out_valid/out_data/out_src   : registered output word and its source
//   out_ready               : downstream accept
//   grant_cnt0/grant_cnt1   : saturating accept counters (ARB2_STATS_EN only)
//
// Build option:
//   ARB2_STATS_EN  - when defined, adds the per-requester grant counters.
// ----------------------------------------------------------------------------
module arb2_rr_ctrl
    import arb2_pkg::*;
#(
    parameter int DATA_W = ARB2_DATA_W,
    parameter int CNT_W  = ARB2_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready
`ifdef ARB2_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic              src_q;
    logic              last_src_q;

    logic              can_load;
    logic              grant_vld;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] mux_out;

    // ------------------------------------------------------------------
    // Arbitration. Under contention the requester that did not win last
    // time is granted; the pointer only moves on an actual accept, so a
    // stalled output never rotates priority.
    // ------------------------------------------------------------------
    assign grant_vld = in0_valid | in1_valid;
    assign grant     = (in0_valid & in1_valid) ? ~last_src_q : in1_valid;
    assign can_load  = (state_q == ST_EMPTY) | out_ready;

    assign in0_ready = can_load & grant_vld & ~grant & in0_valid;
    assign in1_ready = can_load & grant_vld &  grant & in1_valid;
    assign accept    = in0_ready | in1_ready;

    mux2to1 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel_i (grant),
        .a0_i  (in0_data),
        .a1_i  (in1_data),
        .y_o   (mux_out)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. An accept always leaves the register FULL
    // (this covers drain-and-reload); a drain with no accept empties it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        if (state_q == ST_FULL) out_valid = 1'b1;
    end

    // ------------------------------------------------------------------
    // Output word, source tag and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            src_q      <= 1'b0;
            last_src_q <= LAST_SRC_RST;
        end else if (accept) begin
            data_q     <= mux_out;
            src_q      <= grant;
            last_src_q <= grant;
        end
    end

    assign out_data = data_q;
    assign out_src  = src_q;

`ifdef ARB2_STATS_EN
    // ------------------------------------------------------------------
    // Saturating accept counters, one per requester
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       acc_vec;

    assign acc_vec = {in1_ready, in0_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[gi] <= '0;
            end else if (acc_vec[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = cnt_q[0];
    assign grant_cnt1 = cnt_q[1];
`endif

endmodule : arb2_rr_ctrl

// File: doc/arb2_rr_ctrl.md
# arb2_rr_ctrl

Two-requester round-robin arbiter and output-register controller for the shared 32-bit 2:1 datapath mux. Each requester presents data over a valid/ready handshake. The block drives the mux select, registers the winner's word, and presents it downstream over a valid/ready handshake. It sits between two producers (e.g. ALU result and load-data paths) and a single consumer port.

## Interface
- DATA_W, 32, data width of both inputs and the output
- CNT_W, 16, width of grant counters (used only with ARB2_STATS_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- in0_valid  in  1  requester 0 has data
- in0_data  in  DATA_W  requester 0 word
- in0_ready  out  1  requester 0 word accepted this cycle
- in1_valid  in  1  requester 1 has data
- in1_data  in  DATA_W  requester 1 word
- in1_ready  out  1  requester 1 word accepted this cycle
- out_valid  out  1  out_data holds a word
- out_data  out  DATA_W  registered granted word
- out_src  out  1  index of the requester that produced out_data
- out_ready  in  1  consumer accepts out_data
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-word counters (ARB2_STATS_EN only)

## Operation
- Two states:
  - EMPTY: output register invalid.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | out_ready.
- Grant (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester NOT equal to last_src.
  - Neither valid: no grant.
- sel to the mux = granted index.
- inX_ready = can_load & grant==X & inX_valid. At most one ready is high per cycle.
- Accept (a ready high):
  - out_data <= mux output.
  - out_src <= grant.
  - last_src <= grant.
  - state <= FULL.
- Transitions:
  - EMPTY, no request: stay EMPTY.
  - FULL, out_ready=1, no request: EMPTY.
  - FULL, out_ready=0: hold data, src, and state. Both readies are 0.
  - FULL, out_ready=1, request present: drain and load in the same cycle; stay FULL (back-to-back, one word per cycle).
- Requesters must hold valid and data stable until ready. The block does not check this.
- The arbitration pointer moves only on accept. A stalled output never rotates priority.

## Timing
- Reset values:
  - state=EMPTY, out_valid=0, out_data=0, out_src=0.
  - last_src=1, so requester 0 wins the first contention.
  - grant_cnt0/1=0.
- Latency: input accepted in cycle N → out_valid in cycle N+1.
- Throughput: 1 word/cycle with out_ready held high.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1…
- inX_ready is combinational from inX_valid/in1_valid/out_ready/state. There are no combinational paths from data inputs to control outputs.
- Reset mid-transfer: the registered word is discarded and out_valid drops asynchronously.

## Configuration
- ARB2_STATS_EN defined:
  - grant_cnt0/grant_cnt1 increment on each accept from the matching requester.
  - Counters saturate at 2^CNT_W−1 (no wrap).
- ARB2_STATS_EN undefined:
  - Counter ports and logic are absent.
  - Arbitration behaviour is identical.

## Structure
- Package arb2_pkg:
  - State encoding (EMPTY=1'b0, FULL=1'b1).
  - Default DATA_W/CNT_W constants.
  - Reset-value constant for last_src.
- Sub-module: one instance of mux2to1 (DATA_W=32) for the data path, select driven by the grant.
- Control, pointer, and counters stay in arb2_rr_ctrl.

## Test plan
- Reset, then only in0_valid=1 with data 0xAAAA_0001, out_ready=1 → in0_ready=1 in cycle 0; out_valid=1, out_data=0xAAAA_0001, out_src=0 in cycle 1.
- Both valid continuously (data 0x1111_1111 / 0x2222_2222), out_ready=1 for 6 cycles → out_src sequence 0,1,0,1,0,1 with matching data, no bubbles.
- FULL with out_ready=0 for 3 cycles while both valid → out_data unchanged, both readies 0, last_src unchanged; on release the next grant goes to the other requester.
- FULL, out_ready=1, no requests → out_valid falls the next cycle; state is EMPTY.
- Assert rst_n=0 mid-stream with out_valid=1 → out_valid=0 immediately; after release requester 0 wins the first contention.
- ARB2_STATS_EN, CNT_W=4: 20 accepts from requester 1 → grant_cnt1=15 (saturated), grant_cnt0=0.
